stoch_stream_sequencer: RTL and testbench
=========================================

// Module: stoch_stream_sequencer
// PURPOSE
//   Sequences one bounded stochastic-stream window for NCH probability channels.
//   Captures NCH decimal probabilities (x/2^ND) on START and steps one shared LFSR.
//   Each RUN cycle it emits one registered stochastic bit per channel (D_k > R_k),
//   then raises DONE.
//   Sits between the decimal-probability sources and the stochastic network inputs.
//   Also returns per-channel ones counts so the window can be checked.
// PARAMETERS
//   ND       8      precision of each probability; LFSR width
//   NCH      4      number of channels sharing the LFSR
//   LEN_W    16     stream-length and ones-counter width
//   SEED     8'h01  LFSR value loaded on INIT; must be nonzero
// PORTS
//   CLK      in   1          clock, all state on posedge
//   INIT     in   1          synchronous active-high reset
//   START    in   1          request a window; sampled only in IDLE
//   ABORT    in   1          terminate RUN immediately, no DONE
//   D_IN     in   NCH*ND     packed probabilities, channel k = D_IN[k*ND +: ND]
//   LEN      in   LEN_W      window length in cycles, sampled with START
//   BUSY     out  1          high in RUN and DONE states
//   S        out  NCH        stochastic bits, channel k = S[k]
//   S_VALID  out  1          S holds a valid stream bit this cycle
//   DONE     out  1          one-cycle pulse after the last valid bit
//   COUNT    out  NCH*LEN_W  ones seen per channel this window; stable from DONE until next START
// BEHAVIOUR
//   - INIT: state=IDLE, LFSR=SEED, S=0, S_VALID=0, DONE=0, BUSY=0, COUNT=0, D/len regs=0.
//     INIT overrides every other input and aborts any window mid-operation.
//   - FSM states: IDLE, RUN, FIN.
//       IDLE & START & LEN!=0 -> RUN: latch D_IN and LEN; clear COUNT.
//       IDLE & START & LEN==0 -> FIN: COUNT cleared; no valid bits.
//       RUN & ABORT           -> IDLE: S_VALID=0 next cycle; no DONE; COUNT holds partial value.
//       RUN & remaining==1    -> FIN.
//       FIN                   -> IDLE unconditionally.
//   - START outside IDLE is ignored, including in the FIN cycle.
//   - ABORT outside RUN is ignored. START and ABORT together in IDLE: START wins.
//   - Each RUN cycle (registered):
//       R_k = LFSR rotated left by (k mod ND)
//       S[k] <= (D_k > R_k)
//       S_VALID <= 1
//       COUNT_k += S[k]-next
//       LFSR steps, remaining--
//   - Latency:
//       START sampled at edge e0; S_VALID is high for exactly LEN consecutive cycles
//       from edge e1; DONE is high for one cycle immediately after the last S_VALID.
//       BUSY is high from e0 through the DONE cycle.
//   - LFSR: Fibonacci, maximal length; taps in package; period 2^ND-1; never 0.
//     It steps only in RUN and is not reseeded between windows.
//     Consequences: D=0 always gives S=0; D=2^ND-1 gives S=0 only when R_k = 2^ND-1.
//   - COUNT_k saturates at 2^LEN_W-1; it cannot overflow because the count is at most LEN.
//   - Comparison is unsigned, ND bits, strict greater-than.
// STRUCTURE
//   - Package stoch_pkg: state encoding (IDLE/RUN/FIN), LFSR tap masks per ND,
//     default SEED, rotate function.
//   - Sub-module stoch_lfsr (ND, SEED; CLK, INIT, EN, Q) instantiated once.
//   - Comparators, counters and FSM live in this module.
// TESTING
//   1. INIT held 3 cycles mid-RUN -> next cycle all outputs 0, state IDLE, LFSR=SEED.
//   2. D=all 0x00, LEN=10 -> S_VALID high exactly 10 cycles, S=0 throughout,
//      DONE 1 cycle later, COUNT all 0.
//   3. ND=8, SEED=1, D_0=0xFF, LEN=255 -> COUNT_0=254; D_0=0x80, LEN=255 -> COUNT_0=127.
//   4. LEN=0 with START -> DONE one cycle after START accepted, no S_VALID, COUNT=0.
//   5. ABORT on 4th RUN cycle of LEN=20 -> S_VALID seen 3 cycles then 0, no DONE,
//      BUSY low next cycle.
//   6. START pulsed during RUN and during FIN -> ignored; window length and
//      COUNT unchanged; a new START in IDLE restarts and LFSR continues its sequence.

Source files
------------

// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic stream sequencer.
// FSM encoding, LFSR tap masks and the channel rotate function.
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // Fibonacci feedback masks (bit i set = stage i+1 tapped), maximal length
    function automatic logic [31:0] lfsr_taps(input int nd);
        logic [31:0] t;
        case (nd)
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0E08;
            13:      t = 32'h0000_1C80;
            14:      t = 32'h0000_3802;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_B400;
            default: t = 32'h0000_00B8;
        endcase
        return t;
    endfunction

    // Rotate the low n bits of x left by sh (sh < n, x confined to n bits)
    function automatic logic [31:0] rotl(
        input logic [31:0] x,
        input int          sh,
        input int          n
    );
        logic [31:0] m;
        m = (32'h1 << n) - 32'h1;
        return ((x << sh) | (x >> (n - sh))) & m;
    endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// Shared maximal-length Fibonacci LFSR for the stream sequencer.
// Loads SEED on init and advances only while en is high.
module stoch_lfsr
    import stoch_pkg::*;
#(
    parameter int            ND   = 8,
    parameter logic [ND-1:0] SEED = ND'(DEFAULT_SEED)
) (
    input  logic          clk,
    input  logic          init,
    input  logic          en,
    output logic [ND-1:0] q
);

    localparam logic [ND-1:0] TAPS = ND'(lfsr_taps(ND));

    logic fb;

    assign fb = ^(q & TAPS);

    always_ff @(posedge clk) begin
        if (init) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[ND-2:0], fb};
        end
    end

endmodule

// File: rtl/stoch_stream_sequencer.sv
// Emits one bounded stochastic-bit window for NCH probability channels.
// One shared LFSR, rotated per channel, is compared against latched probabilities.
module stoch_stream_sequencer
    import stoch_pkg::*;
#(
    parameter int            ND    = 8,
    parameter int            NCH   = 4,
    parameter int            LEN_W = 16,
    parameter logic [ND-1:0] SEED  = ND'(DEFAULT_SEED)
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCH*ND-1:0]    d_in,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic [NCH-1:0]       s,
    output logic                 s_valid,
    output logic                 done,
    output logic [NCH*LEN_W-1:0] count
);

    state_e state, state_nx;

    logic [ND-1:0]    lq;
    logic [ND-1:0]    d_q [NCH];
    logic [LEN_W-1:0] cnt [NCH];
    logic [LEN_W-1:0] rem;
    logic [NCH-1:0]   s_nx;
    logic             step;
    logic             accept;

    stoch_lfsr #(
        .ND   (ND),
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .init (init),
        .en   (step),
        .q    (lq)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign s_nx[k] = d_q[k] > ND'(rotl(32'(lq), k % ND, ND));
        assign count[k*LEN_W +: LEN_W] = cnt[k];
    end

    assign accept = (state == IDLE) && start;
    // done is registered after FIN, so it extends busy by one cycle
    assign busy   = (state != IDLE) || done;

    always_comb begin
        state_nx = state;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    step = 1'b1;
                    if (rem == LEN_W'(1)) begin
                        state_nx = FIN;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state   <= IDLE;
            s       <= '0;
            s_valid <= 1'b0;
            done    <= 1'b0;
            rem     <= '0;
        end else begin
            state   <= state_nx;
            s       <= step ? s_nx : '0;
            s_valid <= step;
            done    <= (state == FIN);
            if (accept) begin
                rem <= len;
            end else if (step) begin
                rem <= rem - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (init) begin
                d_q[k] <= '0;
                cnt[k] <= '0;
            end else if (accept) begin
                d_q[k] <= d_in[k*ND +: ND];
                cnt[k] <= '0;
            end else if (step && s_nx[k] && (cnt[k] != '1)) begin
                cnt[k] <= cnt[k] + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stoch_stream_sequencer.sv
// Directed vector bench for stoch_stream_sequencer.
// Windows come from a table; init mid-run is a hand sequence.
module tb_stoch_stream_sequencer;

    logic        clk = 1'b0;
    logic        init;
    logic        start;
    logic        abort;
    logic [31:0] d_in;
    logic [15:0] len;
    logic        busy;
    logic [3:0]  s;
    logic        s_valid;
    logic        done;
    logic [63:0] count;

    always #5 clk = ~clk;

    stoch_stream_sequencer dut (
        .clk     (clk),
        .init    (init),
        .start   (start),
        .abort   (abort),
        .d_in    (d_in),
        .len     (len),
        .busy    (busy),
        .s       (s),
        .s_valid (s_valid),
        .done    (done),
        .count   (count)
    );

    typedef struct {
        logic [31:0] d;
        int          ln;
        logic [63:0] cnt;
        bit          chk_cnt;
        int          abort_at;
        bit          ab0;
        bit          poke;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m;
    int         mc [4];
    vec_t       tv [9];

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR: x^8+x^6+x^5+x^4+1 taps, shifting towards the MSB
    function automatic logic [7:0] nxt(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [7:0] rot(input logic [7:0] x, input int k);
        logic [15:0] t;
        t = {x, x} << k;
        return t[15:8];
    endfunction

    task automatic run(input vec_t v);
        logic [3:0]  es;
        logic [63:0] ec;
        logic        ev;
        int          endi;
        for (int k = 0; k < 4; k++) mc[k] = 0;
        d_in  = v.d;
        len   = 16'(v.ln);
        start = 1'b1;
        abort = v.ab0;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("busy_e0", busy, 1);
        endi = (v.abort_at > 0) ? v.abort_at + 2 : v.ln + 3;
        for (int i = 1; i <= endi; i++) begin
            if (v.abort_at == i) abort = 1'b1;
            if (v.poke && (i == 2 || i == v.ln + 1)) begin
                start = 1'b1;
                len   = 16'd3;
                d_in  = ~v.d;
            end
            tick;
            start = 1'b0;
            abort = 1'b0;
            ev = (v.abort_at > 0) ? (i < v.abort_at) : (i <= v.ln);
            chk("s_valid", s_valid, ev);
            chk("done", done, (v.abort_at == 0) && (i == v.ln + 1));
            chk("busy", busy,
                (v.abort_at > 0) ? (i < v.abort_at) : (i <= v.ln + 1));
            if (ev) begin
                for (int k = 0; k < 4; k++) begin
                    es[k] = v.d[k*8 +: 8] > rot(m, k);
                    mc[k] += int'(es[k]);
                end
                chk("s_bits", s, es);
                m = nxt(m);
            end
        end
        for (int k = 0; k < 4; k++) ec[k*16 +: 16] = 16'(mc[k]);
        chk("count_model", count, ec);
        if (v.chk_cnt) chk("count_table", count, v.cnt);
    endtask

    initial begin
        tv[0] = '{32'h0000_0000, 10, 64'h0, 1'b1, 0, 1'b0, 1'b0};
        tv[1] = '{32'hFF80_4000, 255,
                  {16'd254, 16'd127, 16'd63, 16'd0}, 1'b1, 0, 1'b0, 1'b0};
        tv[2] = '{32'h0110_FF80, 255,
                  {16'd0, 16'd15, 16'd254, 16'd127}, 1'b1, 0, 1'b0, 1'b0};
        tv[3] = '{32'h0000_00FF, 255,
                  {16'd0, 16'd0, 16'd0, 16'd254}, 1'b1, 0, 1'b0, 1'b0};
        tv[4] = '{32'hFFFF_FFFF, 0, 64'h0, 1'b1, 0, 1'b0, 1'b0};
        tv[5] = '{32'h1234_5678, 20, 64'h0, 1'b0, 4, 1'b0, 1'b0};
        tv[6] = '{32'hA0B0_C0D0, 6, 64'h0, 1'b0, 0, 1'b1, 1'b0};
        tv[7] = '{32'h8080_8080, 12, 64'h0, 1'b0, 0, 1'b0, 1'b1};
        tv[8] = '{32'h3C5A_96F0, 9, 64'h0, 1'b0, 0, 1'b0, 1'b0};

        init  = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        d_in  = '0;
        len   = '0;
        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_s", s, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        init = 1'b0;
        tick;
        chk("idle_busy", busy, 0);
        m = 8'h01;

        for (int i = 0; i < 9; i++) run(tv[i]);

        // init held three cycles in the middle of a window
        d_in  = 32'hFFFF_FFFF;
        len   = 16'd20;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        init = 1'b1;
        repeat (3) tick;
        init = 1'b0;
        chk("init_busy", busy, 0);
        chk("init_s", s, 0);
        chk("init_valid", s_valid, 0);
        chk("init_done", done, 0);
        chk("init_count", count, 0);
        tick;
        chk("init_idle", busy, 0);
        chk("init_novalid", s_valid, 0);
        m = 8'h01;
        run('{32'hFFFF_FFFF, 5, 64'h0, 1'b0, 0, 1'b0, 1'b0});
        run('{32'h4080_C020, 7, 64'h0, 1'b0, 0, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
